// File: rtl/unidade_escrita.sv
// Write-back unit: queues ALU/memory results in a small FIFO and drives one bank write per cycle.
// Latency: an entry accepted into an empty FIFO is on the outputs one edge later. Pronto reflects free slots, not a same-cycle pop.
module unidade_escrita #(
   parameter int LARGURA      = 8,
   parameter int BITS_REG     = 3,
   parameter int PROFUNDIDADE = 4
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Halt,
   input  logic                MemValido,
   input  logic [BITS_REG-1:0] MemReg,
   input  logic [LARGURA-1:0]  MemDado,
   output logic                MemPronto,
   input  logic                AluValido,
   input  logic [BITS_REG-1:0] AluReg,
   input  logic [LARGURA-1:0]  AluDado,
   output logic                AluPronto,
   output logic                Sobrescrever,
   output logic [BITS_REG-1:0] RegEscrito,
   output logic [LARGURA-1:0]  DadoEscrito,
   input  logic [BITS_REG-1:0] RegConsulta,
   output logic                Pendente,
   output logic [LARGURA-1:0]  DadoPendente,
   output logic                Parado
);

   localparam int PW = $clog2(PROFUNDIDADE);

   typedef enum logic [1:0] {OPERANDO, DRENANDO, PARADO} estado_t;

   estado_t estado, estado_prox;

   logic [BITS_REG-1:0] fila_reg  [PROFUNDIDADE];
   logic [LARGURA-1:0]  fila_dado [PROFUNDIDADE];
   logic [PW-1:0]       ptr_esc, ptr_lei, ptr_alu;
   logic [PW:0]         contagem, livres;
   logic                aceita_mem, aceita_alu, retira;

   assign livres     = (PW+1)'(PROFUNDIDADE) - contagem;
   assign MemPronto  = (estado == OPERANDO) && (livres != '0);
   // ALU may take the last slot only when memory is not competing for it.
   assign AluPronto  = (estado == OPERANDO) &&
                       ((livres >= (PW+1)'(2)) || ((livres == (PW+1)'(1)) && !MemValido));
   assign aceita_mem = MemValido && MemPronto;
   assign aceita_alu = AluValido && AluPronto;
   assign retira     = (contagem != '0);
   assign ptr_alu    = ptr_esc + PW'(aceita_mem);

   always_ff @(posedge Clock) begin
      if (aceita_mem) begin
         fila_reg[ptr_esc]  <= MemReg;
         fila_dado[ptr_esc] <= MemDado;
      end
      if (aceita_alu) begin
         fila_reg[ptr_alu]  <= AluReg;
         fila_dado[ptr_alu] <= AluDado;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ptr_esc      <= '0;
         ptr_lei      <= '0;
         contagem     <= '0;
         estado       <= OPERANDO;
         Sobrescrever <= 1'b0;
         RegEscrito   <= '0;
         DadoEscrito  <= '0;
         Parado       <= 1'b0;
      end else begin
         ptr_esc  <= ptr_esc + PW'(aceita_mem) + PW'(aceita_alu);
         ptr_lei  <= ptr_lei + PW'(retira);
         contagem <= contagem + (PW+1)'(aceita_mem) + (PW+1)'(aceita_alu) - (PW+1)'(retira);
         estado   <= estado_prox;
         Parado   <= (estado_prox == PARADO);
         Sobrescrever <= retira;
         if (retira) begin
            RegEscrito  <= fila_reg[ptr_lei];
            DadoEscrito <= fila_dado[ptr_lei];
         end
      end
   end

   always_comb begin
      estado_prox = estado;
      case (estado)
         OPERANDO: if (Halt) estado_prox = DRENANDO;
         DRENANDO: if ((contagem == '0) && !Sobrescrever) estado_prox = PARADO;
         PARADO:   estado_prox = PARADO;
         default:  estado_prox = OPERANDO;
      endcase
   end

   // Walk oldest to youngest so the newest matching entry ends up winning.
   always_comb begin
      Pendente     = 1'b0;
      DadoPendente = '0;
      if (Sobrescrever && (RegEscrito == RegConsulta)) begin
         Pendente     = 1'b1;
         DadoPendente = DadoEscrito;
      end
      for (int i = 0; i < PROFUNDIDADE; i++) begin
         if (((PW+1)'(i) < contagem) && (fila_reg[ptr_lei + PW'(i)] == RegConsulta)) begin
            Pendente     = 1'b1;
            DadoPendente = fila_dado[ptr_lei + PW'(i)];
         end
      end
   end

endmodule

// File: tb/tb_unidade_escrita.sv
// Bench for unidade_escrita: queue-based reference model of the write-back FIFO and drain FSM.
module tb_unidade_escrita;

   localparam int LARGURA  = 8;
   localparam int BITS_REG = 3;
   localparam int PROF     = 4;

   logic                Clock = 1'b0;
   logic                Reset, Halt;
   logic                MemValido, AluValido, MemPronto, AluPronto;
   logic [BITS_REG-1:0] MemReg, AluReg, RegEscrito, RegConsulta;
   logic [LARGURA-1:0]  MemDado, AluDado, DadoEscrito, DadoPendente;
   logic                Sobrescrever, Pendente, Parado;

   unidade_escrita #(.LARGURA(LARGURA), .BITS_REG(BITS_REG), .PROFUNDIDADE(PROF)) dut (
      .Clock(Clock), .Reset(Reset), .Halt(Halt),
      .MemValido(MemValido), .MemReg(MemReg), .MemDado(MemDado), .MemPronto(MemPronto),
      .AluValido(AluValido), .AluReg(AluReg), .AluDado(AluDado), .AluPronto(AluPronto),
      .Sobrescrever(Sobrescrever), .RegEscrito(RegEscrito), .DadoEscrito(DadoEscrito),
      .RegConsulta(RegConsulta), .Pendente(Pendente), .DadoPendente(DadoPendente),
      .Parado(Parado)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [BITS_REG-1:0] r;
      logic [LARGURA-1:0]  d;
   } ent_t;

   ent_t                q[$];
   bit                  halted, parked, exp_sobre;
   logic [BITS_REG-1:0] exp_reg;
   logic [LARGURA-1:0]  exp_dado;
   int                  tests = 0, fails = 0;
   int                  n_acc = 0, n_wr = 0;

   task automatic model_reset();
      q.delete();
      halted = 0; parked = 0; exp_sobre = 0;
      exp_reg = '0; exp_dado = '0;
   endtask

   task automatic idle_inputs();
      MemValido = 0; AluValido = 0; Halt = 0;
      MemReg = '0; AluReg = '0; MemDado = '0; AluDado = '0;
   endtask

   // One clock cycle: inputs are already driven during the low phase.
   task automatic step();
      bit                 mp, ap, pend, acc_m, acc_a;
      int                 livres;
      logic [LARGURA-1:0] pdat;
      ent_t               e;
      #1;
      livres = PROF - q.size();
      mp = !halted && (livres >= 1);
      ap = !halted && ((livres >= 2) || (livres == 1 && !MemValido));
      pend = 0; pdat = '0;
      if (exp_sobre && exp_reg == RegConsulta) begin pend = 1; pdat = exp_dado; end
      foreach (q[i]) if (q[i].r == RegConsulta) begin pend = 1; pdat = q[i].d; end
      tests += 4;
      if (MemPronto !== mp) begin fails++; $display("FAIL MemPronto t=%0t got %b want %b", $time, MemPronto, mp); end
      if (AluPronto !== ap) begin fails++; $display("FAIL AluPronto t=%0t got %b want %b", $time, AluPronto, ap); end
      if (Pendente !== pend) begin fails++; $display("FAIL Pendente t=%0t got %b want %b", $time, Pendente, pend); end
      if (DadoPendente !== pdat) begin fails++; $display("FAIL DadoPendente t=%0t got %h want %h", $time, DadoPendente, pdat); end
      @(posedge Clock);
      acc_m = MemValido && mp;
      acc_a = AluValido && ap;
      if (!halted) begin
         if (Halt) halted = 1;
      end else if (!parked && q.size() == 0 && !exp_sobre) parked = 1;
      if (q.size() > 0) begin
         e = q.pop_front();
         exp_sobre = 1; exp_reg = e.r; exp_dado = e.d;
      end else exp_sobre = 0;
      if (acc_m) begin e.r = MemReg; e.d = MemDado; q.push_back(e); n_acc++; end
      if (acc_a) begin e.r = AluReg; e.d = AluDado; q.push_back(e); n_acc++; end
      #1;
      if (Sobrescrever === 1'b1) n_wr++;
      tests += 4;
      if (Sobrescrever !== exp_sobre) begin fails++; $display("FAIL Sobrescrever t=%0t got %b want %b", $time, Sobrescrever, exp_sobre); end
      if (RegEscrito !== exp_reg) begin fails++; $display("FAIL RegEscrito t=%0t got %0d want %0d", $time, RegEscrito, exp_reg); end
      if (DadoEscrito !== exp_dado) begin fails++; $display("FAIL DadoEscrito t=%0t got %h want %h", $time, DadoEscrito, exp_dado); end
      if (Parado !== parked) begin fails++; $display("FAIL Parado t=%0t got %b want %b", $time, Parado, parked); end
      @(negedge Clock);
   endtask

   task automatic drain();
      int n = 0;
      idle_inputs();
      while ((q.size() != 0 || exp_sobre) && n < 20) begin step(); n++; end
      tests++;
      if (q.size() != 0 || exp_sobre) begin
         fails++; $display("FAIL drain_timeout left=%0d want 0", q.size());
      end
   endtask

   task automatic test_reset();
      Reset = 1; idle_inputs(); RegConsulta = '0;
      model_reset();
      #2;
      tests += 5;
      if (Sobrescrever !== 1'b0) begin fails++; $display("FAIL reset_sobre got %b want 0", Sobrescrever); end
      if (RegEscrito !== '0) begin fails++; $display("FAIL reset_reg got %0d want 0", RegEscrito); end
      if (DadoEscrito !== '0) begin fails++; $display("FAIL reset_dado got %h want 0", DadoEscrito); end
      if (Parado !== 1'b0) begin fails++; $display("FAIL reset_parado got %b want 0", Parado); end
      if (Pendente !== 1'b0) begin fails++; $display("FAIL reset_pendente got %b want 0", Pendente); end
      @(negedge Clock);
      Reset = 0;
   endtask

   task automatic test_single();
      MemValido = 1; MemReg = 3'd3; MemDado = 8'hA5;
      step();
      idle_inputs();
      step();
      tests++;
      if (!(Sobrescrever === 1'b1 && RegEscrito === 3'd3 && DadoEscrito === 8'hA5)) begin
         fails++; $display("FAIL single_write got %b/%0d/%h want 1/3/a5", Sobrescrever, RegEscrito, DadoEscrito);
      end
      step();
      tests++;
      if (Sobrescrever !== 1'b0) begin fails++; $display("FAIL single_after got %b want 0", Sobrescrever); end
   endtask

   task automatic test_pair();
      MemValido = 1; MemReg = 3'd1; MemDado = 8'h11;
      AluValido = 1; AluReg = 3'd2; AluDado = 8'h22;
      step();
      idle_inputs();
      step();
      tests++;
      if (!(Sobrescrever === 1'b1 && RegEscrito === 3'd1 && DadoEscrito === 8'h11)) begin
         fails++; $display("FAIL pair_first got %b/%0d/%h want 1/1/11", Sobrescrever, RegEscrito, DadoEscrito);
      end
      step();
      tests++;
      if (!(Sobrescrever === 1'b1 && RegEscrito === 3'd2 && DadoEscrito === 8'h22)) begin
         fails++; $display("FAIL pair_second got %b/%0d/%h want 1/2/22", Sobrescrever, RegEscrito, DadoEscrito);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int acc0 = n_acc, wr0 = n_wr;
      for (int c = 0; c < 6; c++) begin
         MemValido = 1; MemReg = 3'(c);     MemDado = 8'(8'h40 + c);
         AluValido = 1; AluReg = 3'(c + 4); AluDado = 8'(8'h80 + c);
         RegConsulta = 3'(c);
         step();
      end
      drain();
      tests++;
      if ((n_wr - wr0) != (n_acc - acc0)) begin
         fails++; $display("FAIL b2b_count got %0d writes want %0d", n_wr - wr0, n_acc - acc0);
      end
   endtask

   task automatic test_same_dest();
      RegConsulta = 3'd5;
      MemValido = 1; MemReg = 3'd5; MemDado = 8'h10;
      step();
      MemDado = 8'h20;
      step();
      idle_inputs();
      #1;
      tests++;
      if (!(Pendente === 1'b1 && DadoPendente === 8'h20)) begin
         fails++; $display("FAIL same_dest_pend got %b/%h want 1/20", Pendente, DadoPendente);
      end
      drain();
      #1;
      tests++;
      if (!(Pendente === 1'b0 && DadoPendente === 8'h00)) begin
         fails++; $display("FAIL same_dest_clear got %b/%h want 0/00", Pendente, DadoPendente);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         MemValido = ($urandom_range(0, 99) < 55);
         AluValido = ($urandom_range(0, 99) < 55);
         MemReg = 3'($urandom_range(0, 7)); MemDado = 8'($urandom);
         AluReg = 3'($urandom_range(0, 7)); AluDado = 8'($urandom);
         RegConsulta = 3'($urandom_range(0, 7));
         step();
      end
      drain();
   endtask

   task automatic test_reset_mid();
      MemValido = 1; MemReg = 3'd6; MemDado = 8'h61;
      AluValido = 1; AluReg = 3'd7; AluDado = 8'h71;
      step();
      AluValido = 0; MemDado = 8'h62;
      step();
      idle_inputs();
      #2 Reset = 1;
      #1;
      tests += 2;
      if (Sobrescrever !== 1'b0) begin fails++; $display("FAIL midreset_sobre got %b want 0", Sobrescrever); end
      if (Pendente !== 1'b0) begin fails++; $display("FAIL midreset_pend got %b want 0", Pendente); end
      model_reset();
      #1 Reset = 0;
      repeat (4) step();
   endtask

   task automatic test_halt();
      int n = 0;
      MemValido = 1; MemReg = 3'd1; MemDado = 8'hC1;
      AluValido = 1; AluReg = 3'd2; AluDado = 8'hC2;
      step();
      AluValido = 0; MemReg = 3'd3; MemDado = 8'hC3; Halt = 1;
      step();
      AluValido = 1;
      #1;
      tests++;
      if (MemPronto !== 1'b0 || AluPronto !== 1'b0) begin
         fails++; $display("FAIL halt_pronto got %b%b want 00", MemPronto, AluPronto);
      end
      while (!parked && n < 20) begin step(); n++; end
      tests++;
      if (!parked) begin fails++; $display("FAIL halt_timeout parked %b want 1", parked); end
      Halt = 0; MemValido = 0; AluValido = 0;
      repeat (3) step();
      tests++;
      if (Parado !== 1'b1) begin fails++; $display("FAIL halt_stays got %b want 1", Parado); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_pair();
      test_back_to_back();
      test_same_dest();
      test_random();
      test_reset_mid();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
